// File: rtl/uart_recv_if.sv
// Serial line, rate select and received-byte outputs of the UART receiver.
interface uart_recv_if;
  logic       uart_rx;
  logic [2:0] baud_set;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;
  logic       uart_state;

  modport slave  (input  uart_rx, baud_set,
                  output data_byte, rx_done, frame_err, uart_state);
  modport master (output uart_rx, baud_set,
                  input  data_byte, rx_done, frame_err, uart_state);
endinterface

// File: rtl/uart_recv_top.sv
// 8N1 UART receiver: 3-sample majority vote at mid-bit, decision at mid-stop.
//
// state | meaning
// IDLE  | waiting for a synced falling edge on the line
// START | timing the start bit, rejects false starts
// DATA  | shifting in 8 data bits, LSB first
// STOP  | mid-stop decision: rx_done or frame_err, then IDLE
module uart_recv_top #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input logic      clk,
  input logic      nrst,
  uart_recv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [12:0] DIV_9600   = 13'(CLK_FREQ / 9600);
  localparam logic [12:0] DIV_19200  = 13'(CLK_FREQ / 19200);
  localparam logic [12:0] DIV_38400  = 13'(CLK_FREQ / 38400);
  localparam logic [12:0] DIV_57600  = 13'(CLK_FREQ / 57600);
  localparam logic [12:0] DIV_115200 = 13'(CLK_FREQ / 115200);
  localparam logic [12:0] DIV_230400 = 13'(CLK_FREQ / 230400);
  localparam logic [12:0] DIV_460800 = 13'(CLK_FREQ / 460800);
  localparam logic [12:0] DIV_921600 = 13'(CLK_FREQ / 921600);

  state_t      state, state_nx;
  logic        rx_s1, rx_s2, rx_d, fall;
  logic [12:0] cnt, cnt_nx, div_q, div_nx, div_sel, half;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic [7:0]  shift_q, shift_nx, data_q, data_nx;
  logic        smp0, smp1, smp0_nx, smp1_nx, maj;
  logic        at_s0, at_s1, at_dec;
  logic        done_q, done_nx, err_q, err_nx, busy_q;

  assign fall = rx_d & ~rx_s2;

  always_comb begin
    div_sel = DIV_9600;
    case (bus.baud_set)
      3'd0: div_sel = DIV_9600;
      3'd1: div_sel = DIV_19200;
      3'd2: div_sel = DIV_38400;
      3'd3: div_sel = DIV_57600;
      3'd4: div_sel = DIV_115200;
      3'd5: div_sel = DIV_230400;
      3'd6: div_sel = DIV_460800;
      3'd7: div_sel = DIV_921600;
      default: div_sel = DIV_9600;
    endcase
  end

  assign half   = div_q >> 1;
  assign at_s0  = (cnt == half - 13'd1);
  assign at_s1  = (cnt == half);
  assign at_dec = (cnt == half + 13'd1);
  // third vote is the live synced sample taken at the decision offset
  assign maj    = (smp0 & smp1) | (smp0 & rx_s2) | (smp1 & rx_s2);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    div_nx     = div_q;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift_q;
    data_nx    = data_q;
    smp0_nx    = smp0;
    smp1_nx    = smp1;
    done_nx    = 1'b0;
    err_nx     = 1'b0;

    if (state != IDLE) begin
      cnt_nx = (cnt == div_q - 13'd1) ? 13'd0 : cnt + 13'd1;
      if (at_s0) smp0_nx = rx_s2;
      if (at_s1) smp1_nx = rx_s2;
    end

    case (state)
      IDLE: begin
        cnt_nx = 13'd0;
        // the detect cycle itself is offset 0 of the start window
        if (fall) begin
          state_nx = START;
          cnt_nx   = 13'd1;
          div_nx   = div_sel;
        end
      end
      START: begin
        if (at_dec) begin
          if (maj) begin
            state_nx = IDLE;
          end else begin
            state_nx   = DATA;
            bit_cnt_nx = 3'd0;
          end
        end
      end
      DATA: begin
        if (at_dec) begin
          shift_nx   = {maj, shift_q[7:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (at_dec) begin
          state_nx = IDLE;
          if (maj) begin
            done_nx = 1'b1;
            data_nx = shift_q;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_d    <= 1'b1;
      state   <= IDLE;
      cnt     <= 13'd0;
      div_q   <= 13'd0;
      bit_cnt <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      smp0    <= 1'b1;
      smp1    <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rx_s1   <= bus.uart_rx;
      rx_s2   <= rx_s1;
      rx_d    <= rx_s2;
      state   <= state_nx;
      cnt     <= cnt_nx;
      div_q   <= div_nx;
      bit_cnt <= bit_cnt_nx;
      shift_q <= shift_nx;
      data_q  <= data_nx;
      smp0    <= smp0_nx;
      smp1    <= smp1_nx;
      done_q  <= done_nx;
      err_q   <= err_nx;
      busy_q  <= (state_nx != IDLE);
    end
  end

  assign bus.data_byte  = data_q;
  assign bus.rx_done    = done_q;
  assign bus.frame_err  = err_q;
  assign bus.uart_state = busy_q;

endmodule
